mux_2t1_5: RTL and testbench

MUX_2T1_5 -- requirements
Module: mux_2t1_5

---
 rtl/mux_2t1_5_if.sv | 30 +++
 rtl/mux_2t1_5.sv | 59 +++++
 tb/tb_mux_2t1_5.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/mux_2t1_5_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// mux_2t1_5_if : signal bundle for the 2:1 mux with registered capture path
// Revision 1.0
// ============================================================================
interface mux_2t1_5_if #(
  parameter int W = 5
);
  logic [W-1:0] I0;
  logic [W-1:0] I1;
  logic         s;
  logic         en;
  logic [W-1:0] o;
  logic [W-1:0] o_q;
  logic         sel_q;
  logic         vld;
  logic [7:0]   sw_cnt;

  modport master (
    output I0, I1, s, en,
    input  o, o_q, sel_q, vld, sw_cnt
  );

  modport slave (
    input  I0, I1, s, en,
    output o, o_q, sel_q, vld, sw_cnt
  );
endinterface
`default_nettype wire

// File: rtl/mux_2t1_5.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// mux_2t1_5 : 2:1 mux with enabled capture register and select-change counter
// Revision 1.0
// ============================================================================
module mux_2t1_5 #(
  parameter int W = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  mux_2t1_5_if.slave  bus
);

  localparam logic [7:0] C_CNT_MAX = 8'd255;

  logic [W-1:0] w_o;
  logic [W-1:0] r_o_q;
  logic         r_sel_q;
  logic         r_vld;
  logic [7:0]   r_sw_cnt;
  logic         w_sel_change;

  // An unknown select falls to the else branch, so o resolves to I0 in simulation.
  always_comb begin
    w_o = bus.I0;
    if (bus.s) begin
      w_o = bus.I1;
    end
  end

  assign w_sel_change = bus.en && (bus.s != r_sel_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_o_q    <= '0;
      r_sel_q  <= 1'b0;
      r_vld    <= 1'b0;
      r_sw_cnt <= 8'd0;
    end else begin
      r_vld <= bus.en;
      if (bus.en) begin
        r_o_q   <= w_o;
        r_sel_q <= bus.s;
      end
      if (w_sel_change && (r_sw_cnt != C_CNT_MAX)) begin
        r_sw_cnt <= r_sw_cnt + 8'd1;
      end
    end
  end

  assign bus.o      = w_o;
  assign bus.o_q    = r_o_q;
  assign bus.sel_q  = r_sel_q;
  assign bus.vld    = r_vld;
  assign bus.sw_cnt = r_sw_cnt;

endmodule
`default_nettype wire

// File: tb/tb_mux_2t1_5.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_mux_2t1_5 : scoreboard bench for mux_2t1_5
// Revision 1.0
// ============================================================================
module tb_mux_2t1_5;

  typedef struct packed {
    logic [4:0] oq;
    logic       sel;
    logic [7:0] cnt;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  exp_t q[$];

  logic [4:0] m_oq;
  logic       m_sel;
  logic [7:0] m_cnt;

  mux_2t1_5_if #(.W(5)) bus ();

  mux_2t1_5 #(.W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Issue one enabled capture and queue what the registers must show after the edge.
  task automatic cap(input logic [4:0] a, input logic [4:0] b, input logic sv);
    exp_t e;
    @(negedge clk);
    bus.I0 = a;
    bus.I1 = b;
    bus.s  = sv;
    bus.en = 1'b1;
    e.oq = sv ? b : a;
    if ((sv != m_sel) && (m_cnt != 8'd255)) m_cnt = m_cnt + 8'd1;
    m_sel = sv;
    m_oq  = e.oq;
    e.sel = sv;
    e.cnt = m_cnt;
    q.push_back(e);
  endtask

  task automatic hold(input logic sv);
    @(negedge clk);
    bus.en = 1'b0;
    bus.s  = sv;
    @(posedge clk);
    #2;
    chk("hold_o_q", 32'(bus.o_q), 32'(m_oq));
    chk("hold_sel_q", 32'(bus.sel_q), 32'(m_sel));
    chk("hold_sw_cnt", 32'(bus.sw_cnt), 32'(m_cnt));
    chk("hold_vld", 32'(bus.vld), 32'd0);
  endtask

  task automatic chk_regs_zero(input string tag);
    chk({tag, "_o_q"}, 32'(bus.o_q), 32'd0);
    chk({tag, "_sel_q"}, 32'(bus.sel_q), 32'd0);
    chk({tag, "_vld"}, 32'(bus.vld), 32'd0);
    chk({tag, "_sw_cnt"}, 32'(bus.sw_cnt), 32'd0);
  endtask

  // Monitor: whenever vld is up, the oldest queued expectation must match.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (bus.vld === 1'b1) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected_vld: got vld=1 expected no capture at %0t", $time);
        end else begin
          e = q.pop_front();
          chk("sb_o_q", 32'(bus.o_q), 32'(e.oq));
          chk("sb_sel_q", 32'(bus.sel_q), 32'(e.sel));
          chk("sb_sw_cnt", 32'(bus.sw_cnt), 32'(e.cnt));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks = 0;
    errors = 0;
    m_oq = '0; m_sel = 1'b0; m_cnt = 8'd0;
    rst_n  = 1'b0;
    bus.I0 = 5'h00; bus.I1 = 5'h00; bus.s = 1'b0; bus.en = 1'b0;
    #2;
    chk_regs_zero("reset");
    chk("truth_00", 32'(bus.o), 32'h00);
    bus.I0 = 5'h0A; bus.I1 = 5'h15; #1;
    chk("truth_s0", 32'(bus.o), 32'h0A);
    bus.s = 1'b1; #1;
    chk("truth_s1", 32'(bus.o), 32'h15);

    // Exhaustive combinational sweep with the register path idle.
    for (int a = 0; a < 32; a++) begin
      for (int b = 0; b < 32; b++) begin
        for (int sv = 0; sv < 2; sv++) begin
          bus.I0 = 5'(a); bus.I1 = 5'(b); bus.s = sv[0];
          #1;
          chk("sweep_o", 32'(bus.o), (sv == 1) ? 32'(b) : 32'(a));
        end
      end
    end
    chk_regs_zero("sweep_idle");

    @(negedge clk);
    rst_n = 1'b1;

    cap(5'h00, 5'h11, 1'b1);
    hold(1'b0);
    chk("cap_o_q_11", 32'(bus.o_q), 32'h11);
    chk("cap_sel_q_1", 32'(bus.sel_q), 32'd1);
    chk("first_s1_counts", 32'(bus.sw_cnt), 32'd1);

    // Input changes between edges reach o only.
    #1;
    bus.s = 1'b0; bus.I0 = 5'h1F; #1;
    chk("mid_o", 32'(bus.o), 32'h1F);
    chk("mid_o_q", 32'(bus.o_q), 32'h11);

    cap(5'h07, 5'h07, 1'b0);
    #1;
    chk("eq_o", 32'(bus.o), 32'h07);
    cap(5'h07, 5'h07, 1'b1);
    cap(5'h1F, 5'h00, 1'b1);
    hold(1'b0);
    chk("eq_cnt", 32'(bus.sw_cnt), 32'd3);

    // Async reset between edges.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_regs_zero("async_rst");
    bus.I0 = 5'h03; bus.I1 = 5'h1C; bus.s = 1'b1; #1;
    chk("rst_o_tracks", 32'(bus.o), 32'h1C);
    m_oq = '0; m_sel = 1'b0; m_cnt = 8'd0;
    @(negedge clk);
    rst_n = 1'b1;

    // Reset held at an edge with a live capture request.
    cap(5'h02, 5'h11, 1'b1);
    hold(1'b0);
    @(negedge clk);
    bus.en = 1'b1; bus.s = 1'b1; bus.I1 = 5'h1F; rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk_regs_zero("rst_vs_cap");
    @(negedge clk);
    bus.en = 1'b0; rst_n = 1'b1;
    m_oq = '0; m_sel = 1'b0; m_cnt = 8'd0;

    for (int i = 0; i < 300; i++) begin
      cap(5'(i), 5'(i + 7), ~i[0]);
    end
    hold(1'b0);
    chk("cnt_saturated", 32'(bus.sw_cnt), 32'd255);
    hold(1'b1);
    hold(1'b0);
    hold(1'b1);
    chk("cnt_no_change_en0", 32'(bus.sw_cnt), 32'd255);

    repeat (3) @(negedge clk);
    chk("sb_drained", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
